// File: rtl/lpc_postcode_pkg.sv
// lpc_postcode_pkg: shared offsets, control bits, scan states and hex glyphs for the POST-code port
package lpc_postcode_pkg;
  localparam logic [15:0] OFS_DATA = 16'd0;
  localparam logic [15:0] OFS_POP  = 16'd1;
  localparam logic [15:0] OFS_STAT = 16'd2;
  localparam int CTL_FLUSH   = 0;
  localparam int CTL_OVF_CLR = 1;
  typedef enum logic [1:0] {ST_DIG1, ST_BLANK0, ST_DIG0, ST_BLANK1} scan_st_t;
  // active-low glyphs, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] SEG_TBL [16] = '{
    ~7'h3F, ~7'h06, ~7'h5B, ~7'h4F, ~7'h66, ~7'h6D, ~7'h7D, ~7'h07,
    ~7'h7F, ~7'h6F, ~7'h77, ~7'h7C, ~7'h39, ~7'h5E, ~7'h79, ~7'h71
  };
endpackage

// File: rtl/postcode_hist_fifo.sv
// postcode_hist_fifo: ring-buffer history with push-overwrite, pop, flush and occupancy count
module postcode_hist_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     lclk,
  input  logic                     lreset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign full  = count == CNT_MAX;
  assign empty = count == '0;
  assign rdata = mem[rp];
  always_ff @(posedge lclk)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge lclk) begin
    if (lreset || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (push) begin
      wp <= wp + 1'b1;
      if (full) rp <= rp + 1'b1;
      else count <= count + 1'b1;
    end else if (pop && !empty) begin
      rp <= rp + 1'b1;
      count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/lpc_postcode_ctrl.sv
// lpc_postcode_ctrl: LPC POST-code port with history readback; 7-seg scan built under LPC_POSTCODE_DISP_EN
module lpc_postcode_ctrl
  import lpc_postcode_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0080,
  parameter int          DEPTH     = 16,
  parameter int          SCAN_DIV  = 1024
) (
  input  logic                   lclk,
  input  logic                   lreset,
  input  logic                   device_cs,
  input  logic [15:0]            addr,
  input  logic [7:0]             din,
  input  logic                   io_wren,
  input  logic                   io_rden,
  output logic [7:0]             dout,
  output logic                   dout_oe,
  output logic [7:0]             postcode,
  output logic [$clog2(DEPTH):0] hist_count,
  output logic                   overflow,
  output logic [6:0]             seg_n,
  output logic [1:0]             dig_n
);
  logic [15:0] ofs;
  logic wr_acc, rd_acc, rd_hit, push, pop, flush, ovf_clr, full, empty;
  logic [7:0] fifo_rdata, rd_data;
  logic [6:0] cnt7;
  assign ofs     = addr - BASE_ADDR;
  assign wr_acc  = device_cs & io_wren;
  assign rd_acc  = device_cs & io_rden & ~io_wren;
  assign rd_hit  = rd_acc & (ofs < 16'd3);
  assign push    = wr_acc & (ofs == OFS_DATA);
  assign flush   = wr_acc & (ofs == OFS_STAT) & din[CTL_FLUSH];
  assign ovf_clr = wr_acc & (ofs == OFS_STAT) & din[CTL_OVF_CLR];
  assign pop     = rd_acc & (ofs == OFS_POP);
  assign cnt7    = (int'(hist_count) > 127) ? 7'h7F : 7'(hist_count);
  assign rd_data = (ofs == OFS_DATA) ? postcode :
                   (ofs == OFS_POP)  ? (empty ? 8'hFF : fifo_rdata) :
                   {overflow, cnt7};
  postcode_hist_fifo #(.DEPTH(DEPTH)) u_hist (
    .lclk  (lclk),
    .lreset(lreset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (din),
    .rdata (fifo_rdata),
    .count (hist_count),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge lclk) begin
    if (lreset) begin
      postcode <= '0;
      dout <= '0;
      dout_oe <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dout_oe <= rd_hit;
      if (rd_hit) dout <= rd_data;
      if (push) postcode <= din;
      if (push && full) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end
`ifdef LPC_POSTCODE_DISP_EN
  localparam int PW = $clog2(SCAN_DIV);
  scan_st_t st, st_nx;
  logic [PW-1:0] pre, pre_nx;
  logic [6:0] seg_nx;
  logic [1:0] dig_nx;
  logic tick;
  assign tick = pre == PW'(SCAN_DIV - 1);
  always_ff @(posedge lclk) begin
    if (lreset) begin
      st <= ST_BLANK1;
      pre <= '0;
      seg_n <= 7'h7F;
      dig_n <= 2'b11;
    end else begin
      st <= st_nx;
      pre <= pre_nx;
      seg_n <= seg_nx;
      dig_n <= dig_nx;
    end
  end
  // glyph is sampled only on the slot boundary so a mid-slot write never tears a digit
  always_comb begin
    st_nx = st;
    pre_nx = tick ? '0 : pre + 1'b1;
    seg_nx = seg_n;
    dig_nx = dig_n;
    if (tick) begin
      st_nx = (st == ST_DIG1)   ? ST_BLANK0 :
              (st == ST_BLANK0) ? ST_DIG0 :
              (st == ST_DIG0)   ? ST_BLANK1 : ST_DIG1;
      seg_nx = (st_nx == ST_DIG1) ? SEG_TBL[postcode[7:4]] :
               (st_nx == ST_DIG0) ? SEG_TBL[postcode[3:0]] : 7'h7F;
      dig_nx = (st_nx == ST_DIG1) ? 2'b01 :
               (st_nx == ST_DIG0) ? 2'b10 : 2'b11;
    end
  end
`else
  assign seg_n = 7'h7F;
  assign dig_n = 2'b11;
`endif
endmodule

// File: tb/tb_lpc_postcode_ctrl.sv
// tb_lpc_postcode_ctrl: vector table, directed corner sequences and random traffic against a queue model
module tb_lpc_postcode_ctrl;
`ifdef LPC_POSTCODE_DISP_EN
  localparam bit DISP = 1'b1;
`else
  localparam bit DISP = 1'b0;
`endif
  logic lclk = 1'b0, lreset, device_cs, io_wren, io_rden, dout_oe, overflow;
  logic [15:0] addr;
  logic [7:0] din, dout, postcode;
  logic [4:0] hist_count;
  logic [6:0] seg_n;
  logic [1:0] dig_n;
  int total = 0, bad = 0;
  logic [7:0] q[$];
  logic [7:0] m_post, m_dout;
  logic m_oe, m_ovf;
  localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef struct {
    logic cs, wr, rd;
    logic [15:0] a;
    logic [7:0] d, dout;
    logic oe;
    logic [7:0] post;
    logic [4:0] cnt;
    logic ovf;
  } vec_t;
  vec_t tv [16];

  lpc_postcode_ctrl #(.BASE_ADDR(16'h0080), .DEPTH(16), .SCAN_DIV(4)) dut (
    .lclk(lclk), .lreset(lreset), .device_cs(device_cs), .addr(addr), .din(din),
    .io_wren(io_wren), .io_rden(io_rden), .dout(dout), .dout_oe(dout_oe),
    .postcode(postcode), .hist_count(hist_count), .overflow(overflow),
    .seg_n(seg_n), .dig_n(dig_n)
  );
  always #5 lclk = ~lclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mreset();
    q.delete();
    m_post = 8'h00; m_dout = 8'h00; m_oe = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model(input logic cs, wr, rd, input logic [15:0] a, input logic [7:0] d);
    logic [15:0] o;
    o = a - 16'h0080;
    m_oe = 1'b0;
    if (cs && wr) begin
      if (o == 16'd0) begin
        m_post = d;
        if (q.size() == 16) begin
          void'(q.pop_front());
          m_ovf = 1'b1;
        end
        q.push_back(d);
      end else if (o == 16'd2) begin
        if (d[0]) q.delete();
        if (d[1]) m_ovf = 1'b0;
      end
    end else if (cs && rd && o < 16'd3) begin
      m_oe = 1'b1;
      if (o == 16'd0) m_dout = m_post;
      else if (o == 16'd1) m_dout = (q.size() > 0) ? q.pop_front() : 8'hFF;
      else m_dout = {m_ovf, (q.size() > 127) ? 7'h7F : 7'(q.size())};
    end
  endtask

  task automatic step(input logic r, cs, wr, rd, input logic [15:0] a, input logic [7:0] d);
    lreset = r; device_cs = cs; io_wren = wr; io_rden = rd; addr = a; din = d;
    @(posedge lclk);
    #1;
    if (r) mreset();
    else model(cs, wr, rd, a, d);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout"}, dout, m_dout);
    chk({tag, ".oe"}, dout_oe, m_oe);
    chk({tag, ".post"}, postcode, m_post);
    chk({tag, ".cnt"}, hist_count, q.size());
    chk({tag, ".ovf"}, overflow, m_ovf);
  endtask

  function automatic vec_t v(input logic cs, wr, rd, input logic [15:0] a, input logic [7:0] d, dout,
                             input logic oe, input logic [7:0] post, input logic [4:0] cnt, input logic ovf);
    v = '{cs, wr, rd, a, d, dout, oe, post, cnt, ovf};
  endfunction

  initial begin
    logic [1:0] st;
    logic [3:0] lat;
    logic [1:0] edig;
    logic [6:0] eseg;
    logic [7:0] d;
    logic [15:0] a;
    logic cs, wr, rd;
    int r;
    tv[0]  = v(1'b1, 1'b1, 1'b0, 16'h80, 8'hA5, 8'h00, 1'b0, 8'hA5, 5'd1, 1'b0);
    tv[1]  = v(1'b1, 1'b0, 1'b1, 16'h81, 8'h00, 8'hA5, 1'b1, 8'hA5, 5'd0, 1'b0);
    tv[2]  = v(1'b1, 1'b0, 1'b1, 16'h81, 8'h00, 8'hFF, 1'b1, 8'hA5, 5'd0, 1'b0);
    tv[3]  = v(1'b1, 1'b0, 1'b1, 16'h82, 8'h00, 8'h00, 1'b1, 8'hA5, 5'd0, 1'b0);
    tv[4]  = v(1'b1, 1'b0, 1'b1, 16'h80, 8'h00, 8'hA5, 1'b1, 8'hA5, 5'd0, 1'b0);
    tv[5]  = v(1'b1, 1'b1, 1'b0, 16'h83, 8'h5A, 8'hA5, 1'b0, 8'hA5, 5'd0, 1'b0);
    tv[6]  = v(1'b1, 1'b1, 1'b0, 16'h81, 8'h77, 8'hA5, 1'b0, 8'hA5, 5'd0, 1'b0);
    tv[7]  = v(1'b0, 1'b1, 1'b0, 16'h80, 8'h11, 8'hA5, 1'b0, 8'hA5, 5'd0, 1'b0);
    tv[8]  = v(1'b1, 1'b1, 1'b0, 16'h80, 8'h3C, 8'hA5, 1'b0, 8'h3C, 5'd1, 1'b0);
    tv[9]  = v(1'b1, 1'b0, 1'b1, 16'h82, 8'h00, 8'h01, 1'b1, 8'h3C, 5'd1, 1'b0);
    tv[10] = v(1'b1, 1'b1, 1'b1, 16'h80, 8'h42, 8'h01, 1'b0, 8'h42, 5'd2, 1'b0);
    tv[11] = v(1'b1, 1'b0, 1'b1, 16'h84, 8'h00, 8'h01, 1'b0, 8'h42, 5'd2, 1'b0);
    tv[12] = v(1'b1, 1'b0, 1'b1, 16'h81, 8'h00, 8'h3C, 1'b1, 8'h42, 5'd1, 1'b0);
    tv[13] = v(1'b1, 1'b1, 1'b0, 16'h82, 8'h01, 8'h3C, 1'b0, 8'h42, 5'd0, 1'b0);
    tv[14] = v(1'b1, 1'b0, 1'b1, 16'h7F, 8'h00, 8'h3C, 1'b0, 8'h42, 5'd0, 1'b0);
    tv[15] = v(1'b0, 1'b0, 1'b1, 16'h81, 8'h00, 8'h3C, 1'b0, 8'h42, 5'd0, 1'b0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    chk("rst.post", postcode, 8'h00);
    chk("rst.dout", dout, 8'h00);
    chk("rst.oe", dout_oe, 1'b0);
    chk("rst.cnt", hist_count, 5'd0);
    chk("rst.ovf", overflow, 1'b0);
    chk("rst.seg", seg_n, 7'h7F);
    chk("rst.dig", dig_n, 2'b11);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, tv[i].cs, tv[i].wr, tv[i].rd, tv[i].a, tv[i].d);
      chk($sformatf("vec%0d.dout", i), dout, tv[i].dout);
      chk($sformatf("vec%0d.oe", i), dout_oe, tv[i].oe);
      chk($sformatf("vec%0d.post", i), postcode, tv[i].post);
      chk($sformatf("vec%0d.cnt", i), hist_count, tv[i].cnt);
      chk($sformatf("vec%0d.ovf", i), overflow, tv[i].ovf);
    end

    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'h80, 8'(i));
      chk($sformatf("fill%0d.cnt", i), hist_count, (i < 16) ? i + 1 : 16);
      chk($sformatf("fill%0d.ovf", i), overflow, i >= 16);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h82, 8'h00);
    chk("full.stat", dout, 8'h90);
    for (int i = 2; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 16'h81, 8'h00);
      chk($sformatf("pop%0d.dout", i), dout, 8'(i));
      chk($sformatf("pop%0d.oe", i), dout_oe, 1'b1);
    end
    chk("pop.cnt", hist_count, 5'd8);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h82, 8'h03);
    chk("clr.cnt", hist_count, 5'd0);
    chk("clr.ovf", overflow, 1'b0);
    chk("clr.post", postcode, 8'h11);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h80, 8'h6E);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h81, 8'h00);
    chk("pushpop.dout", dout, 8'h6E);
    chk("pushpop.cnt", hist_count, 5'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    chk("oe.pulse", dout_oe, 1'b0);

    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 99));
      a = (r < 50) ? 16'h80 : (r < 75) ? 16'h81 : (r < 90) ? 16'h82 : 16'h80 + 16'($urandom_range(3, 5));
      cs = $urandom_range(0, 7) != 0;
      r = int'($urandom_range(0, 99));
      wr = r < 55 || r >= 95;
      rd = r >= 55;
      d = 8'($urandom);
      if (a == 16'h82 && $urandom_range(0, 5) != 0) d[0] = 1'b0;
      step(1'b0, cs, wr, rd, a, d);
      check_model($sformatf("rnd%0d", n));
    end

    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h82, 8'h03);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h80, 8'(8'hD0 + i));
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    chk("midrst.pre", hist_count, 5'd5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    chk("midrst.cnt", hist_count, 5'd0);
    chk("midrst.seg", seg_n, 7'h7F);
    chk("midrst.dig", dig_n, 2'b11);
    chk("midrst.post", postcode, 8'h00);
    chk("midrst.ovf", overflow, 1'b0);

    st = 2'd0;
    lat = 4'h0;
    for (int k = 1; k <= 40; k++) begin
      if (k % 4 == 0) begin
        st = 2'((k / 4) % 4);
        lat = (st == 2'd1) ? m_post[7:4] : m_post[3:0];
      end
      d = (k == 1) ? 8'h3C : (k == 13) ? 8'h5F : (k == 26) ? 8'hE7 : 8'h00;
      step(1'b0, d != 8'h00, d != 8'h00, 1'b0, 16'h80, d);
      edig = !DISP ? 2'b11 : (st == 2'd1) ? 2'b01 : (st == 2'd3) ? 2'b10 : 2'b11;
      eseg = (!DISP || !st[0]) ? 7'h7F : GLY[lat];
      chk($sformatf("scan%0d.dig", k), dig_n, edig);
      chk($sformatf("scan%0d.seg", k), seg_n, eseg);
    end
    check_model("scan.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
